soc_mem_arbiter: RTL
====================

// Module: soc_mem_arbiter
// PURPOSE
//  Two-master arbiter sharing one single-port synchronous memory between the
//  RV32I fetch port (IF, read-only) and the load/store port (LS, read/write).
//  Sits between soc_riscv_32i core ports and the unified instr/data RAM.
//  Issues at most one memory command per cycle, pipelined, and routes read
//  data back to the issuing master after MEM_LAT cycles.
// PARAMETERS
//  AW         32  byte-address width
//  MEM_LAT    1   memory read latency in cycles (1..4)
//  PRIO_LS    1   1 = LS fixed priority with starvation guard; 0 = round-robin
//  STARVE_MAX 3   consecutive IF denials before IF is forced a grant (1..15)
// PORTS
//  iCLK        in   1   clock, rising edge
//  iRST        in   1   asynchronous reset, active-low
//  iIF_REQ     in   1   fetch request; held with iIF_ADDR until oIF_GNT
//  iIF_ADDR    in   AW  fetch byte address (word aligned)
//  oIF_GNT     out  1   fetch accepted this cycle
//  oIF_RVALID  out  1   oIF_RDATA valid
//  oIF_RDATA   out  32  fetch read data
//  iLS_REQ     in   1   load/store request; held with fields until oLS_GNT
//  iLS_WE      in   1   1 = store, 0 = load
//  iLS_BE      in   4   byte enables for store
//  iLS_ADDR    in   AW  load/store byte address
//  iLS_WDATA   in   32  store data
//  oLS_GNT     out  1   load/store accepted this cycle
//  oLS_RVALID  out  1   oLS_RDATA valid (loads only)
//  oLS_RDATA   out  32  load read data
//  oMEM_EN     out  1   memory command valid
//  oMEM_WE     out  1   memory write
//  oMEM_BE     out  4   memory byte enables (4'hF on reads)
//  oMEM_ADDR   out  AW-2 memory word address = selected addr[AW-1:2]
//  oMEM_WDATA  out  32  memory write data
//  iMEM_RDATA  in   32  memory read data, valid MEM_LAT cycles after read cmd
// BEHAVIOUR
//  - Reset (iRST=0, async): all outputs 0, starvation counter 0, RR pointer=IF,
//    response pipeline cleared. Outstanding reads are dropped, never returned.
//  - Grant is combinational from current requests + registered state; exactly
//    one of oIF_GNT/oLS_GNT high iff any request high. Memory command driven
//    same cycle from the granted master; oMEM_EN = oIF_GNT | oLS_GNT.
//  - PRIO_LS=1: LS wins ties unless starve counter == STARVE_MAX, then IF wins.
//    Counter +1 each cycle IF requests and is denied; cleared on IF grant or
//    IF idle; saturates at STARVE_MAX.
//  - PRIO_LS=0: on tie grant master != last granted; pointer updates on grant.
//  - Single requester always granted immediately; back-to-back grants allowed.
//  - Response pipe: MEM_LAT-deep shift of {valid, owner}; entry pushed only for
//    reads. At depth MEM_LAT: owner's RVALID=1, RDATA=iMEM_RDATA; other
//    master's RVALID=0, RDATA held at last value (0 after reset).
//  - Stores: no RVALID; store in cycle N visible to any read issued cycle N+1.
//  - Order preserved per master; responses never reorder.
//  - Write with iLS_BE=0 still issues (oMEM_EN=1, oMEM_WE=1, BE=0).
// TESTING
//  1 IF only, addrs 0x0,0x4,0x8 consecutive -> GNT 3 cycles, RVALID cycles
//    1..3 after issue (MEM_LAT=1) with mem words 0,1,2.
//  2 PRIO_LS=1, both req continuously -> LS,LS,LS,IF pattern (STARVE_MAX=3),
//    IF granted on 4th cycle, counter then 0.
//  3 PRIO_LS=0, both req continuously -> grants alternate IF,LS,IF,LS.
//  4 LS store 0xDEADBEEF, BE=4'b0011 @0x10 over 0x0 -> IF read 0x10 next
//    cycle returns 0x0000BEEF; no oLS_RVALID for the store.
//  5 Two IF reads outstanding (MEM_LAT=2), iRST low 1 cycle mid-flight ->
//    outputs 0 at once, no RVALID after release.
//  6 MEM_LAT=3, interleaved IF/LS loads -> each RVALID on correct port, 3 cycles
//    after its grant, data matches address.

Source files
------------

// File: rtl/soc_mem_arbiter.sv
// Two-master arbiter sharing one single-port synchronous RAM between the
// instruction-fetch port (read-only) and the load/store port (read/write).
module soc_mem_arbiter #(
  parameter int AW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int PRIO_LS    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iIF_REQ,
  input  logic [AW-1:0] iIF_ADDR,
  output logic          oIF_GNT,
  output logic          oIF_RVALID,
  output logic [31:0]   oIF_RDATA,
  input  logic          iLS_REQ,
  input  logic          iLS_WE,
  input  logic [3:0]    iLS_BE,
  input  logic [AW-1:0] iLS_ADDR,
  input  logic [31:0]   iLS_WDATA,
  output logic          oLS_GNT,
  output logic          oLS_RVALID,
  output logic [31:0]   oLS_RDATA,
  output logic          oMEM_EN,
  output logic          oMEM_WE,
  output logic [3:0]    oMEM_BE,
  output logic [AW-3:0] oMEM_ADDR,
  output logic [31:0]   oMEM_WDATA,
  input  logic [31:0]   iMEM_RDATA
);

  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]         starve_cnt;
  owner_e             rr_next;
  logic [MEM_LAT-1:0] pipe_vld;
  owner_e             pipe_own [MEM_LAT];
  logic [31:0]        if_hold;
  logic [31:0]        ls_hold;
  logic               if_win;
  logic               if_resp;
  logic               ls_resp;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{iIF_ADDR[1:0], iLS_ADDR[1:0]};

  // Grants are masked by reset so every output reads 0 while iRST is low.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    if_win = iIF_REQ;
    if (iIF_REQ && iLS_REQ) begin
      if (PRIO_LS != 0) if_win = (starve_cnt == STARVE_LIM);
      else              if_win = (rr_next == OWN_IF);
    end
    oIF_GNT = if_win & iRST;
    oLS_GNT = iLS_REQ & ~if_win & iRST;
  end

  always_comb begin
    oMEM_EN    = oIF_GNT | oLS_GNT;
    oMEM_WE    = 1'b0;
    oMEM_BE    = 4'h0;
    oMEM_ADDR  = '0;
    oMEM_WDATA = 32'h0;
    if (oLS_GNT) begin
      oMEM_WE    = iLS_WE;
      oMEM_BE    = iLS_WE ? iLS_BE : 4'hF;
      oMEM_ADDR  = iLS_ADDR[AW-1:2];
      oMEM_WDATA = iLS_WDATA;
    end else if (oIF_GNT) begin
      oMEM_BE    = 4'hF;
      oMEM_ADDR  = iIF_ADDR[AW-1:2];
    end
  end

  assign if_resp = pipe_vld[MEM_LAT-1] && (pipe_own[MEM_LAT-1] == OWN_IF);
  assign ls_resp = pipe_vld[MEM_LAT-1] && (pipe_own[MEM_LAT-1] == OWN_LS);

  // The owner sees live RAM data on its return cycle; otherwise the last word is held.
  assign oIF_RVALID = if_resp;
  assign oLS_RVALID = ls_resp;
  assign oIF_RDATA  = if_resp ? iMEM_RDATA : if_hold;
  assign oLS_RDATA  = ls_resp ? iMEM_RDATA : ls_hold;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      // NOTE: the response pipe is ordinary flops, so it is cleared here; in-flight reads are dropped.
      starve_cnt <= 4'h0;
      rr_next    <= OWN_IF;
      pipe_vld   <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipe_own[i] <= OWN_IF;
      if_hold    <= 32'h0;
      ls_hold    <= 32'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (iIF_REQ && !oIF_GNT)
        starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'h1;
      else
        starve_cnt <= 4'h0;

      if (oIF_GNT)      rr_next <= OWN_LS;
      else if (oLS_GNT) rr_next <= OWN_IF;

      pipe_vld[0] <= oMEM_EN && !oMEM_WE;
      pipe_own[0] <= oLS_GNT ? OWN_LS : OWN_IF;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_own[i] <= pipe_own[i-1];
      end

      if (if_resp) if_hold <= iMEM_RDATA;
      if (ls_resp) ls_hold <= iMEM_RDATA;
    end
  end

endmodule
